add_issue_stage: RTL

Registered issue/retire stage wrapped around the team's 32-bit combinational adder. It accepts operand pairs over a valid/ready handshake and buffers them in a small input queue. It drives the queue head onto the adder inputs, captures the adder's sum into an output register with a signed-overflow flag, and returns results over a second valid/ready handshake. It sits directly upstream and downstream of the adder, turning it into a pipelined, back-pressurable datapath unit.

---
 rtl/add_issue_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/add_issue_stage.sv
// add_issue_stage
//
// Registered issue/retire stage wrapped around the external 32-bit
// combinational adder. Operand pairs come in over a valid/ready handshake and
// wait in a small circular queue. The queue head drives the adder inputs. The
// adder's sum is captured into an output register together with a signed
// overflow flag. Results leave over a second valid/ready handshake.
//
// Configuration macro: ADD_ISSUE_SKID_EN
//   defined   -> queue depth 2, sustains one result per cycle
//   undefined -> queue depth 1, sustains one result every two cycles
//
// Ports:
//   i_clk      clock, all state updates on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    upstream operand pair valid
//   o_ready    stage can accept an operand pair (registered-state only)
//   i_a, i_b   operands
//   o_add_a/b  adder operands = queue head (0 when the queue is empty)
//   i_add_sum  adder result, combinational in o_add_a/o_add_b
//   o_valid    result valid
//   i_ready    downstream accepts the result
//   o_sum      registered sum, modulo 2^32
//   o_ovf      registered signed overflow of o_sum
//   o_count    number of results accepted downstream, wraps

module add_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic [31:0]      i_add_sum,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_sum,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

`ifdef ADD_ISSUE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // One pointer bit covers both depths; with depth 1 the pointers stay at 0.
  localparam int               PTR_W     = 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [1:0]       DEPTH_OCC = 2'(DEPTH);

  logic [31:0]      q_a [DEPTH];
  logic [31:0]      q_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       occ;

  out_state_t state_q;
  out_state_t state_d;

  logic        push;
  logic        iss;
  logic        retire;
  logic [31:0] head_a;
  logic [31:0] head_b;
  logic        ovf_next;

  // Handshake decode and the queue head. o_ready comes only from the
  // occupancy register, so it can never be pulled low combinationally by
  // i_valid or i_ready. An issue can happen whenever the output register is
  // empty or is being drained in this same cycle.
  always_comb begin
    o_ready  = (occ < DEPTH_OCC);
    o_valid  = (state_q == FULL);
    push     = i_valid && o_ready;
    iss      = (occ != 2'd0) && ((state_q == EMPTY) || i_ready);
    retire   = o_valid && i_ready;
    head_a   = 32'd0;
    head_b   = 32'd0;
    if (occ != 2'd0) begin
      head_a = q_a[rd_ptr];
      head_b = q_b[rd_ptr];
    end
    o_add_a  = head_a;
    o_add_b  = head_b;
    // Signed overflow: operands agree in sign but the sum does not.
    ovf_next = (head_a[31] == head_b[31]) && (i_add_sum[31] != head_a[31]);
  end

  // Queue storage. Contents are meaningless until written, so no reset is
  // needed here; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_a[wr_ptr] <= i_a;
      q_b[wr_ptr] <= i_b;
    end
  end

  // Queue bookkeeping. Pointers advance independently and wrap at DEPTH;
  // a simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (iss) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, iss})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Output register state. Issuing always leaves a fresh result held, even
  // when the previous one retires in the same cycle; a retire with nothing
  // to issue empties the register.
  always_comb begin
    state_d = state_q;
    if (iss) begin
      state_d = FULL;
    end else if (retire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result register and completion counter. The sum and flag only change on
  // an issue, so they hold steady while the downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum   <= 32'd0;
      o_ovf   <= 1'b0;
      o_count <= '0;
    end else begin
      if (iss) begin
        o_sum <= i_add_sum;
        o_ovf <= ovf_next;
      end
      if (retire) begin
        o_count <= o_count + CNT_W'(1);
      end
    end
  end

endmodule
